// File: rtl/cpu64_cache_pkg.sv
// ----------------------------------------------------------------------------
// cpu64_cache_pkg
// Shared definitions for the L2/L3 cache controllers: replacement FSM states,
// the tree-PLRU bit-count helper, and the default geometry that the tag array
// and the replacement engine have to agree on.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu64_cache_pkg;

  // Default geometry, shared with the tag array.
  localparam int unsigned DEFAULT_NUM_SETS = 32'd2048;
  localparam int unsigned DEFAULT_NUM_WAYS = 32'd16;

  // Replacement engine top-level states.
  typedef enum logic {
    INIT = 1'b0,  // sequential sweep clearing one set per cycle
    RUN  = 1'b1   // lookups and touches are serviced
  } plru_state_e;

  // A binary tree over `ways` leaves has ways-1 internal nodes.
  function automatic int unsigned plru_tree_bits(input int unsigned ways);
    return ways - 32'd1;
  endfunction

endpackage

// File: rtl/cpu64_plru_tree_walk.sv
// ----------------------------------------------------------------------------
// cpu64_plru_tree_walk
// Purely combinational tree-PLRU victim walk that takes a way-lock mask into
// account. The tree bits are in heap order: node n has children 2n+1 and 2n+2.
// A bit of 0 points into the lower-index subtree and 1 into the upper one. When
// the subtree that a bit points to has no unlocked way, the walk takes the
// other branch.
// Ports:
//   tree_bits_i  - NUM_WAYS-1 PLRU node bits for one set
//   lock_mask_i  - 1 = way may not be chosen
//   way_o        - chosen way (meaningless when none_o = 1)
//   none_o       - every way is locked
// ----------------------------------------------------------------------------
module cpu64_plru_tree_walk
  import cpu64_cache_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = DEFAULT_NUM_WAYS,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned TREE_W   = plru_tree_bits(NUM_WAYS)
) (
  input  logic [TREE_W-1:0]   tree_bits_i,
  input  logic [NUM_WAYS-1:0] lock_mask_i,
  output logic [WAY_W-1:0]    way_o,
  output logic                none_o
);

  // Lock-aware walk from the root. way_v collects the path prefix MSB first.
  always_comb begin
    int   way_v;
    int   node_v;
    logic lo_free;
    logic hi_free;
    logic tbit;
    logic dir;
    way_v   = 0;
    node_v  = 0;
    lo_free = 1'b0;
    hi_free = 1'b0;
    tbit    = 1'b0;
    dir     = 1'b0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      lo_free = 1'b0;
      hi_free = 1'b0;
      // The ways under the current node share the prefix way_v. Split them
      // into the lower and upper halves and note whether each half has a free way.
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
        if ((w >> (int'(WAY_W) - l)) == way_v) begin
          if (((w >> (int'(WAY_W) - 1 - l)) & 1) == 1) begin
            hi_free = hi_free | ~lock_mask_i[w];
          end else begin
            lo_free = lo_free | ~lock_mask_i[w];
          end
        end else begin
          lo_free = lo_free;
        end
      end
      tbit = 1'b0;
      for (int n = 0; n < int'(TREE_W); n++) begin
        if (n == node_v) begin
          tbit = tree_bits_i[n];
        end else begin
          tbit = tbit;
        end
      end
      if (!tbit && !lo_free) begin
        dir = 1'b1;
      end else if (tbit && !hi_free) begin
        dir = 1'b0;
      end else begin
        dir = tbit;
      end
      node_v = 2 * node_v + 1 + int'(dir);
      way_v  = 2 * way_v + int'(dir);
    end
    way_o  = WAY_W'(way_v);
    none_o = &lock_mask_i;
  end

endmodule

// File: rtl/cpu64_cache_plru_pipe.sv
// ----------------------------------------------------------------------------
// cpu64_cache_plru_pipe
// Parametrised tree-PLRU replacement engine that sits beside the tag array.
// After reset, an INIT sweep clears one set per cycle. In RUN the engine
// returns one registered victim per accepted lookup (latency 1, valid/ready),
// applies a per-lookup way-lock mask, and accepts touches. A touch in the same
// cycle as a lookup to the same set is bypassed, so the lookup sees the
// post-touch state.
// Optional feature macro: CPU64_PLRU_STATS_EN. When it is defined, the engine
// adds saturating counters of accepted lookups by outcome.
// Ports:
//   clk_i, rst_ni          - clock, async active-low reset
//   init_done_o            - sweep finished, engine in RUN
//   lookup_*               - victim request (valid/ready), set, valid bits, lock mask
//   victim_*               - registered result (valid/ready), way, none, invalid-hit
//   update_*               - touch: mark way MRU in set (always accepted in RUN)
//   stat_*_cnt_o           - outcome counters (CPU64_PLRU_STATS_EN only)
// ----------------------------------------------------------------------------
module cpu64_cache_plru_pipe
  import cpu64_cache_pkg::*;
#(
  parameter  int unsigned NUM_SETS = DEFAULT_NUM_SETS,
  parameter  int unsigned NUM_WAYS = DEFAULT_NUM_WAYS,
  localparam int unsigned SET_W    = $clog2(NUM_SETS),
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                init_done_o,
  input  logic                lookup_valid_i,
  output logic                lookup_ready_o,
  input  logic [SET_W-1:0]    lookup_set_i,
  input  logic [NUM_WAYS-1:0] lookup_vmask_i,
  input  logic [NUM_WAYS-1:0] lookup_lock_mask_i,
  output logic                victim_valid_o,
  input  logic                victim_ready_i,
  output logic [WAY_W-1:0]    victim_way_o,
  output logic                victim_none_o,
  output logic                victim_inv_o,
  input  logic                update_valid_i,
  input  logic [SET_W-1:0]    update_set_i,
  input  logic [WAY_W-1:0]    update_way_i
`ifdef CPU64_PLRU_STATS_EN
  ,
  output logic [31:0]         stat_inv_cnt_o,
  output logic [31:0]         stat_evict_cnt_o,
  output logic [31:0]         stat_none_cnt_o
`endif
);

  localparam int unsigned TREE_W = plru_tree_bits(NUM_WAYS);

  plru_state_e       state_r;
  plru_state_e       state_next_s;
  logic [SET_W-1:0]  sweep_cnt_r;
  logic              sweep_en_s;
  logic              run_s;
  logic              init_done_r;
  logic [TREE_W-1:0] tree_mem_r [NUM_SETS];

  logic              update_fire_s;
  logic              lookup_ready_s;
  logic              lookup_fire_s;
  logic [TREE_W-1:0] wr_bits_s;
  logic [TREE_W-1:0] lookup_bits_s;
  logic              inv_found_s;
  logic [WAY_W-1:0]  inv_way_s;
  logic [WAY_W-1:0]  walk_way_s;
  logic              walk_none_s;
  logic              victim_valid_r;
  logic [WAY_W-1:0]  victim_way_r;
  logic              victim_none_r;
  logic              victim_inv_r;

  // Every node on the path to `way` points away from the branch that was taken.
  function automatic logic [TREE_W-1:0] touch_bits(input logic [TREE_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [TREE_W-1:0] res;
    int node;
    int d;
    res  = bits;
    node = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      d = (int'(way) >> (int'(WAY_W) - 1 - l)) & 1;
      for (int n = 0; n < int'(TREE_W); n++) begin
        if (n == node) res[n] = (d == 0);
      end
      node = 2 * node + 1 + d;
    end
    return res;
  endfunction

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= INIT;
    else         state_r <= state_next_s;
  end

  // FSM next state: leave INIT once the last set has been cleared.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        if (sweep_cnt_r == SET_W'(NUM_SETS - 32'd1)) state_next_s = RUN;
        else                                         state_next_s = INIT;
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = INIT;
    endcase
  end

  // FSM output decode.
  always_comb begin
    sweep_en_s = 1'b0;
    run_s      = 1'b0;
    case (state_r)
      INIT:    sweep_en_s = 1'b1;
      RUN:     run_s      = 1'b1;
      default: sweep_en_s = 1'b1;
    endcase
  end

  // Sweep counter and registered init-done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sweep_cnt_r <= '0;
      init_done_r <= 1'b0;
    end else begin
      if (sweep_en_s) sweep_cnt_r <= sweep_cnt_r + SET_W'(1);
      init_done_r <= (state_next_s == RUN);
    end
  end

  assign update_fire_s  = run_s & update_valid_i;
  assign lookup_ready_s = run_s & (~victim_valid_r | victim_ready_i);
  assign lookup_fire_s  = lookup_valid_i & lookup_ready_s;
  assign wr_bits_s      = touch_bits(tree_mem_r[update_set_i], update_way_i);

  // PLRU state array. The sweep, not the reset, clears it.
  always_ff @(posedge clk_i) begin
    if (sweep_en_s)         tree_mem_r[sweep_cnt_r]  <= '0;
    else if (update_fire_s) tree_mem_r[update_set_i] <= wr_bits_s;
  end

  // Lookup read with same-cycle touch bypass.
  always_comb begin
    if (update_fire_s && (update_set_i == lookup_set_i)) begin
      lookup_bits_s = wr_bits_s;
    end else begin
      lookup_bits_s = tree_mem_r[lookup_set_i];
    end
  end

  // Lowest-index way that is invalid and not locked. The loop scans downward so the last hit is the lowest index.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!lookup_vmask_i[w] && !lookup_lock_mask_i[w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
    end
  end

  cpu64_plru_tree_walk #(
    .NUM_WAYS (NUM_WAYS)
  ) u_walk (
    .tree_bits_i (lookup_bits_s),
    .lock_mask_i (lookup_lock_mask_i),
    .way_o       (walk_way_s),
    .none_o      (walk_none_s)
  );

  // Victim output register. It holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_valid_r <= 1'b0;
      victim_way_r   <= '0;
      victim_none_r  <= 1'b0;
      victim_inv_r   <= 1'b0;
    end else if (lookup_fire_s) begin
      victim_valid_r <= 1'b1;
      victim_none_r  <= walk_none_s;
      victim_inv_r   <= ~walk_none_s & inv_found_s;
      if (walk_none_s)      victim_way_r <= '0;
      else if (inv_found_s) victim_way_r <= inv_way_s;
      else                  victim_way_r <= walk_way_s;
    end else if (victim_ready_i) begin
      victim_valid_r <= 1'b0;
    end
  end

  assign init_done_o    = init_done_r;
  assign lookup_ready_o = lookup_ready_s;
  assign victim_valid_o = victim_valid_r;
  assign victim_way_o   = victim_way_r;
  assign victim_none_o  = victim_none_r;
  assign victim_inv_o   = victim_inv_r;

`ifdef CPU64_PLRU_STATS_EN
  logic [31:0] stat_inv_r;
  logic [31:0] stat_evict_r;
  logic [31:0] stat_none_r;

  // Saturating counters of accepted lookups, by outcome.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_inv_r   <= 32'd0;
      stat_evict_r <= 32'd0;
      stat_none_r  <= 32'd0;
    end else if (lookup_fire_s) begin
      if (walk_none_s) begin
        if (stat_none_r != 32'hFFFF_FFFF) stat_none_r <= stat_none_r + 32'd1;
      end else if (inv_found_s) begin
        if (stat_inv_r != 32'hFFFF_FFFF) stat_inv_r <= stat_inv_r + 32'd1;
      end else begin
        if (stat_evict_r != 32'hFFFF_FFFF) stat_evict_r <= stat_evict_r + 32'd1;
      end
    end
  end

  assign stat_inv_cnt_o   = stat_inv_r;
  assign stat_evict_cnt_o = stat_evict_r;
  assign stat_none_cnt_o  = stat_none_r;
`endif

endmodule

// File: tb/tb_cpu64_cache_plru_pipe.sv
// ----------------------------------------------------------------------------
// tb_cpu64_cache_plru_pipe
// Directed bench for an 8-set, 4-way cpu64_cache_plru_pipe. The expected
// victims are worked out by hand from the tree-PLRU rules. Inputs change 1 ns
// after each rising edge, and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_cpu64_cache_plru_pipe;

  localparam int unsigned NS = 8;
  localparam int unsigned NW = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       init_done_o;
  logic       lookup_valid_i;
  logic       lookup_ready_o;
  logic [2:0] lookup_set_i;
  logic [3:0] lookup_vmask_i;
  logic [3:0] lookup_lock_mask_i;
  logic       victim_valid_o;
  logic       victim_ready_i;
  logic [1:0] victim_way_o;
  logic       victim_none_o;
  logic       victim_inv_o;
  logic       update_valid_i;
  logic [2:0] update_set_i;
  logic [1:0] update_way_i;
`ifdef CPU64_PLRU_STATS_EN
  logic [31:0] stat_inv_cnt_o;
  logic [31:0] stat_evict_cnt_o;
  logic [31:0] stat_none_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  cpu64_cache_plru_pipe #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .init_done_o        (init_done_o),
    .lookup_valid_i     (lookup_valid_i),
    .lookup_ready_o     (lookup_ready_o),
    .lookup_set_i       (lookup_set_i),
    .lookup_vmask_i     (lookup_vmask_i),
    .lookup_lock_mask_i (lookup_lock_mask_i),
    .victim_valid_o     (victim_valid_o),
    .victim_ready_i     (victim_ready_i),
    .victim_way_o       (victim_way_o),
    .victim_none_o      (victim_none_o),
    .victim_inv_o       (victim_inv_o),
    .update_valid_i     (update_valid_i),
    .update_set_i       (update_set_i),
    .update_way_i       (update_way_i)
`ifdef CPU64_PLRU_STATS_EN
    ,
    .stat_inv_cnt_o     (stat_inv_cnt_o),
    .stat_evict_cnt_o   (stat_evict_cnt_o),
    .stat_none_cnt_o    (stat_none_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_lookup(input logic [2:0] set, input logic [3:0] vm, input logic [3:0] lk);
    lookup_valid_i     = 1'b1;
    lookup_set_i       = set;
    lookup_vmask_i     = vm;
    lookup_lock_mask_i = lk;
    step();
    lookup_valid_i     = 1'b0;
  endtask

  task automatic do_touch(input logic [2:0] set, input logic [1:0] way);
    update_valid_i = 1'b1;
    update_set_i   = set;
    update_way_i   = way;
    step();
    update_valid_i = 1'b0;
  endtask

  task automatic expect_victim(input string tag, input logic [1:0] way,
                               input logic none, input logic inv);
    check_eq({tag, "_valid"}, {31'd0, victim_valid_o}, 32'd1);
    check_eq({tag, "_way"},   {30'd0, victim_way_o},   {30'd0, way});
    check_eq({tag, "_none"},  {31'd0, victim_none_o},  {31'd0, none});
    check_eq({tag, "_inv"},   {31'd0, victim_inv_o},   {31'd0, inv});
  endtask

  // Bounded wait for the sweep. It checks the cycle count and that ready stays low.
  task automatic wait_init(input string tag);
    int   cycles;
    logic ready_seen;
    cycles     = 0;
    ready_seen = 1'b0;
    while (!init_done_o && cycles < 40) begin
      if (lookup_ready_o) ready_seen = 1'b1;
      step();
      cycles++;
    end
    check_eq({tag, "_cycles"}, cycles, 32'd8);
    check_eq({tag, "_ready_in_init"}, {31'd0, ready_seen}, 32'd0);
  endtask

  initial begin
    rst_ni             = 1'b0;
    lookup_valid_i     = 1'b0;
    lookup_set_i       = 3'd0;
    lookup_vmask_i     = 4'hF;
    lookup_lock_mask_i = 4'h0;
    victim_ready_i     = 1'b1;
    update_valid_i     = 1'b0;
    update_set_i       = 3'd0;
    update_way_i       = 2'd0;
    step();
    step();
    check_eq("rst_init_done", {31'd0, init_done_o},    32'd0);
    check_eq("rst_vvalid",    {31'd0, victim_valid_o}, 32'd0);
    check_eq("rst_way",       {30'd0, victim_way_o},   32'd0);
    check_eq("rst_none",      {31'd0, victim_none_o},  32'd0);
    check_eq("rst_inv",       {31'd0, victim_inv_o},   32'd0);
    check_eq("rst_ready",     {31'd0, lookup_ready_o}, 32'd0);

    // Release. During INIT, a pending lookup and a touch to set 3 must both be ignored.
    rst_ni         = 1'b1;
    lookup_valid_i = 1'b1;
    update_valid_i = 1'b1;
    update_set_i   = 3'd3;
    update_way_i   = 2'd0;
    wait_init("init1");
    lookup_valid_i = 1'b0;
    update_valid_i = 1'b0;
    check_eq("init1_no_result", {31'd0, victim_valid_o}, 32'd0);
    check_eq("run_ready",       {31'd0, lookup_ready_o}, 32'd1);

    // Basic PLRU sequence on set 0.
    do_lookup(3'd0, 4'hF, 4'h0);
    expect_victim("fresh", 2'd0, 1'b0, 1'b0);
    do_touch(3'd0, 2'd0);
    check_eq("valid_clears", {31'd0, victim_valid_o}, 32'd0);
    do_lookup(3'd0, 4'hF, 4'h0);
    expect_victim("after_t0", 2'd2, 1'b0, 1'b0);
    do_touch(3'd0, 2'd2);
    do_lookup(3'd0, 4'hF, 4'h0);
    expect_victim("after_t2", 2'd1, 1'b0, 1'b0);
    do_touch(3'd0, 2'd1);
    do_lookup(3'd0, 4'hF, 4'h0);
    expect_victim("after_t1", 2'd3, 1'b0, 1'b0);

    // Invalid ways take priority, unless they are locked.
    do_lookup(3'd1, 4'b1011, 4'b0000);
    expect_victim("inv_way2", 2'd2, 1'b0, 1'b1);
    do_lookup(3'd1, 4'b1011, 4'b0100);
    expect_victim("inv_locked", 2'd0, 1'b0, 1'b0);
    do_lookup(3'd1, 4'b0000, 4'b0001);
    expect_victim("inv_lowest", 2'd1, 1'b0, 1'b1);

    // Locks steer the walk. With everything locked there is no victim.
    do_lookup(3'd2, 4'hF, 4'b0111);
    expect_victim("lock_only3", 2'd3, 1'b0, 1'b0);
    do_lookup(3'd2, 4'hF, 4'b1111);
    expect_victim("all_locked", 2'd0, 1'b1, 1'b0);
    do_lookup(3'd2, 4'h0, 4'b1111);
    expect_victim("all_locked_inv", 2'd0, 1'b1, 1'b0);

    // A touch issued during INIT must not have reached set 3.
    do_lookup(3'd3, 4'hF, 4'h0);
    expect_victim("init_touch_ignored", 2'd0, 1'b0, 1'b0);

    // A touch and a lookup to the same set in the same cycle: the lookup sees the post-touch state.
    update_valid_i = 1'b1;
    update_set_i   = 3'd5;
    update_way_i   = 2'd0;
    do_lookup(3'd5, 4'hF, 4'h0);
    update_valid_i = 1'b0;
    expect_victim("bypass", 2'd2, 1'b0, 1'b0);
    step();
    check_eq("drain", {31'd0, victim_valid_o}, 32'd0);

    // Stall: the result holds through touches, and new requests are refused.
    victim_ready_i = 1'b0;
    do_lookup(3'd6, 4'hF, 4'h0);
    expect_victim("stall_first", 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      update_valid_i     = 1'b1;
      update_set_i       = 3'd6;
      update_way_i       = 2'(k);
      lookup_valid_i     = 1'b1;
      lookup_set_i       = 3'd6;
      lookup_lock_mask_i = 4'b0001;
      step();
      expect_victim($sformatf("stall%0d", k), 2'd0, 1'b0, 1'b0);
      check_eq($sformatf("stall%0d_ready", k), {31'd0, lookup_ready_o}, 32'd0);
    end

    // Reset in the middle of the stall.
    rst_ni             = 1'b0;
    update_valid_i     = 1'b0;
    lookup_valid_i     = 1'b0;
    lookup_lock_mask_i = 4'h0;
    #1;
    check_eq("midrst_vvalid",    {31'd0, victim_valid_o}, 32'd0);
    check_eq("midrst_init_done", {31'd0, init_done_o},    32'd0);
    check_eq("midrst_ready",     {31'd0, lookup_ready_o}, 32'd0);
    step();
    rst_ni         = 1'b1;
    victim_ready_i = 1'b1;
    wait_init("init2");

    // The sweep must have cleared the touched sets. These two lookups run back to back.
    do_lookup(3'd6, 4'hF, 4'h0);
    expect_victim("swept_set6", 2'd0, 1'b0, 1'b0);
    do_lookup(3'd0, 4'hF, 4'b0001);
    expect_victim("swept_set0", 2'd1, 1'b0, 1'b0);
    step();
    check_eq("final_drain", {31'd0, victim_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
